// File: rtl/psi_table_gen.sv
`default_nettype none
// ============================================================================
// Module   : psi_table_gen
// Purpose  : Builds the forward (PSI^bitrev(i)) and inverse
//            (PSI_INV^bitrev(i)) twiddle tables mod Q in two register banks.
//            The tables are built after reset or after a regen pulse. When
//            ready, the module serves pipelined reads with one cycle of
//            latency.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            regen_i    - one-cycle pulse, recompute both tables
//            ready_o    - tables valid, reads accepted
//            rd_en_i    - read request
//            rd_inv_i   - bank select (0 = forward, 1 = inverse)
//            rd_addr_i  - table index
//            rd_data_o  - twiddle value
//            rd_valid_o - rd_data_o carries a read result this cycle
// Revision : 1.0 - initial release
// ============================================================================
module psi_table_gen #(
    parameter int N       = 32,
    parameter int LOG_N   = 5,
    parameter int W       = 9,
    parameter int Q       = 257,
    parameter int PSI     = 81,
    parameter int PSI_INV = 165
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regen_i,
    output logic             ready_o,
    input  logic             rd_en_i,
    input  logic             rd_inv_i,
    input  logic [LOG_N-1:0] rd_addr_i,
    output logic [W-1:0]     rd_data_o,
    output logic             rd_valid_o
);

    typedef enum logic [0:0] {
        S_GEN = 1'b0,
        S_RDY = 1'b1
    } state_t;

    // Constants widened to the product width so the modular arithmetic
    // stays within 2W bits.
    localparam logic [2*W-1:0]   c_q       = (2*W)'(Q);
    localparam logic [2*W-1:0]   c_psi     = (2*W)'(PSI);
    localparam logic [2*W-1:0]   c_psi_inv = (2*W)'(PSI_INV);
    localparam logic [W-1:0]     c_one     = W'(1);
    localparam logic [LOG_N-1:0] c_k_last  = LOG_N'(N - 1);

    state_t             state_q;
    logic [LOG_N-1:0]   k_q;
    logic [W-1:0]       acc_f_q;
    logic [W-1:0]       acc_i_q;
    logic               ready_q;
    logic               rd_valid_q;
    logic [W-1:0]       rd_data_q;

    logic [W-1:0]       acc_f_d;
    logic [W-1:0]       acc_i_d;
    logic [LOG_N-1:0]   w_k_rev;
    logic               w_rd_accept;

    logic [W-1:0]       fwd_q [0:N-1];
    logic [W-1:0]       inv_q [0:N-1];

    // Bit-reversed write index. Generation walks the powers in natural
    // order and scatters them into bit-reversed positions.
    genvar gi;
    generate
        for (gi = 0; gi < LOG_N; gi++) begin : g_bitrev
            assign w_k_rev[gi] = k_q[LOG_N-1-gi];
        end
    endgenerate

    // Next running powers. The reduction is complete, so each result is
    // strictly below Q.
    always_comb begin
        acc_f_d = W'(({{W{1'b0}}, acc_f_q} * c_psi) % c_q);
        acc_i_d = W'(({{W{1'b0}}, acc_i_q} * c_psi_inv) % c_q);
    end

    assign w_rd_accept = rd_en_i && ready_q;

    // Generation control. A regen pulse takes priority over the
    // end-of-generation transition, so a pulse in either state restarts
    // generation from k = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_GEN;
            k_q     <= '0;
            acc_f_q <= c_one;
            acc_i_q <= c_one;
            ready_q <= 1'b0;
        end else if (regen_i) begin
            state_q <= S_GEN;
            k_q     <= '0;
            acc_f_q <= c_one;
            acc_i_q <= c_one;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_GEN: begin
                    acc_f_q <= acc_f_d;
                    acc_i_q <= acc_i_d;
                    k_q     <= k_q + LOG_N'(1);
                    if (k_q == c_k_last) begin
                        state_q <= S_RDY;
                        ready_q <= 1'b1;
                    end
                end
                S_RDY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_GEN;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The banks have no reset. Their contents are rewritten in full
    // during every generation pass. A regen in GEN still writes the
    // current entry, and that value is correct for its index.
    always_ff @(posedge clk) begin
        if (state_q == S_GEN && !rst) begin
            fwd_q[w_k_rev] <= acc_f_q;
            inv_q[w_k_rev] <= acc_i_q;
        end
    end

    // Read port. A read that arrives together with regen in RDY is still
    // served, because ready_q is still high at that edge and the banks do
    // not change until the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= w_rd_accept;
            if (w_rd_accept) begin
                rd_data_q <= rd_inv_i ? inv_q[rd_addr_i] : fwd_q[rd_addr_i];
            end
        end
    end

    assign ready_o    = ready_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_psi_table_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_psi_table_gen
// Purpose  : Self-checking bench for psi_table_gen. The expected tables are
//            built by direct modular exponentiation with bit reversal.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_psi_table_gen;

    localparam int N       = 32;
    localparam int LOG_N   = 5;
    localparam int W       = 9;
    localparam int Q       = 257;
    localparam int PSI     = 81;
    localparam int PSI_INV = 165;

    logic             clk;
    logic             rst;
    logic             regen_i;
    logic             ready_o;
    logic             rd_en_i;
    logic             rd_inv_i;
    logic [LOG_N-1:0] rd_addr_i;
    logic [W-1:0]     rd_data_o;
    logic             rd_valid_o;

    int n_checks;
    int n_fail;
    int mf [N];
    int mi [N];

    psi_table_gen #(
        .N(N), .LOG_N(LOG_N), .W(W), .Q(Q), .PSI(PSI), .PSI_INV(PSI_INV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .regen_i   (regen_i),
        .ready_o   (ready_o),
        .rd_en_i   (rd_en_i),
        .rd_inv_i  (rd_inv_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .rd_valid_o(rd_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int modpow(input int b, input int e);
        int r;
        r = 1;
        for (int j = 0; j < e; j++) r = (r * b) % Q;
        return r;
    endfunction

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int j = 0; j < LOG_N; j++) if (((v >> j) & 1) != 0) r |= 1 << (LOG_N - 1 - j);
        return r;
    endfunction

    task automatic build_model();
        for (int i = 0; i < N; i++) begin
            mf[i] = modpow(PSI, bitrev(i));
            mi[i] = modpow(PSI_INV, bitrev(i));
        end
    endtask

    // Advance one clock edge. Sampling happens 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; regen_i = 1'b0; rd_en_i = 1'b0; rd_inv_i = 1'b0; rd_addr_i = '0;
        tick(); tick(); tick();
        n_checks++;
        if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        n_checks++;
        if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rd_valid_o); end
        n_checks++;
        if (rd_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", rd_data_o); end
        rst = 1'b0;
        for (int e = 1; e <= N; e++) begin
            rd_en_i   = 1'($urandom % 2);
            rd_inv_i  = 1'($urandom % 2);
            rd_addr_i = LOG_N'($urandom);
            tick();
            n_checks++;
            if (ready_o !== (e == N)) begin n_fail++; $display("FAIL gen_ready edge %0d: got %b want %b", e, ready_o, (e == N)); end
            n_checks++;
            if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL gen_valid edge %0d: got %b want 0", e, rd_valid_o); end
        end
        rd_en_i = 1'b0;
    endtask

    task automatic test_fixed_reads(input logic inv, input int e0, input int e1, input int e2, input int e3);
        int addrs [4];
        int exps  [4];
        addrs = '{0, 1, 16, 31};
        exps  = '{e0, e1, e2, e3};
        for (int j = 0; j < 4; j++) begin
            rd_en_i = 1'b1; rd_inv_i = inv; rd_addr_i = LOG_N'(addrs[j]);
            tick();
            rd_en_i = 1'b0;
            n_checks++;
            if (rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL fixed_valid inv=%b addr %0d: got %b want 1", inv, addrs[j], rd_valid_o); end
            n_checks++;
            if (rd_data_o !== W'(exps[j])) begin n_fail++; $display("FAIL fixed_data inv=%b addr %0d: got %0d want %0d", inv, addrs[j], rd_data_o, exps[j]); end
            tick();
            n_checks++;
            if (rd_valid_o !== 1'b0 || rd_data_o !== W'(exps[j])) begin
                n_fail++; $display("FAIL idle_hold inv=%b: got v=%b d=%0d want v=0 d=%0d", inv, rd_valid_o, rd_data_o, exps[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int got [2*N];
        for (int j = 0; j < 2*N; j++) begin
            rd_en_i = 1'b1; rd_inv_i = (j >= N); rd_addr_i = LOG_N'(j % N);
            tick();
            got[j] = int'(rd_data_o);
            n_checks++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== W'((j >= N) ? mi[j % N] : mf[j % N])) begin
                n_fail++;
                $display("FAIL b2b entry %0d: got v=%b d=%0d want v=1 d=%0d", j, rd_valid_o, rd_data_o, (j >= N) ? mi[j % N] : mf[j % N]);
            end
        end
        rd_en_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if ((got[i] * got[i + N]) % Q != 1) begin
                n_fail++; $display("FAIL inverse_pair %0d: got %0d want 1", i, (got[i] * got[i + N]) % Q);
            end
        end
    endtask

    task automatic test_random_reads(input int n);
        int last;
        logic en, inv;
        int a;
        last = int'(rd_data_o);
        for (int j = 0; j < n; j++) begin
            en = 1'($urandom % 2); inv = 1'($urandom % 2); a = int'($urandom % N);
            rd_en_i = en; rd_inv_i = inv; rd_addr_i = LOG_N'(a);
            tick();
            if (en) last = inv ? mi[a] : mf[a];
            n_checks++;
            if (rd_valid_o !== en || rd_data_o !== W'(last)) begin
                n_fail++; $display("FAIL rand_read %0d: got v=%b d=%0d want v=%b d=%0d", j, rd_valid_o, rd_data_o, en, last);
            end
        end
        rd_en_i = 1'b0;
    endtask

    task automatic check_gen_window(input string tag);
        for (int e = 1; e <= N; e++) begin
            rd_en_i = 1'($urandom % 2); rd_addr_i = LOG_N'($urandom);
            tick();
            n_checks++;
            if (ready_o !== (e == N) || rd_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL %s edge %0d: got r=%b v=%b want r=%b v=0", tag, e, ready_o, rd_valid_o, (e == N));
            end
        end
        rd_en_i = 1'b0;
    endtask

    task automatic test_regen();
        int a;
        logic inv;
        a = int'($urandom % N); inv = 1'($urandom % 2);
        regen_i = 1'b1; rd_en_i = 1'b1; rd_inv_i = inv; rd_addr_i = LOG_N'(a);
        tick();
        regen_i = 1'b0; rd_en_i = 1'b0;
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== W'(inv ? mi[a] : mf[a]) || ready_o !== 1'b0) begin
            n_fail++; $display("FAIL regen_read: got v=%b d=%0d r=%b want v=1 d=%0d r=0", rd_valid_o, rd_data_o, ready_o, inv ? mi[a] : mf[a]);
        end
        check_gen_window("regen_gen");
        test_random_reads(24);
    endtask

    task automatic test_regen_in_gen();
        regen_i = 1'b1; tick(); regen_i = 1'b0;
        repeat (5) tick();
        regen_i = 1'b1; tick(); regen_i = 1'b0;
        check_gen_window("regen_mid_gen");
        test_random_reads(24);
    endtask

    task automatic test_rst_mid_gen();
        regen_i = 1'b1; tick(); regen_i = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || rd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_gen: got r=%b v=%b want r=0 v=0", ready_o, rd_valid_o);
        end
        tick(); tick();
        rst = 1'b0;
        check_gen_window("rst_gen_regen");
        test_random_reads(24);
    endtask

    task automatic test_rst_mid_read();
        rd_en_i = 1'b1; rd_inv_i = 1'b0; rd_addr_i = LOG_N'(1);
        tick();
        rd_en_i = 1'b0;
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== W'(mf[1])) begin
            n_fail++; $display("FAIL pre_rst_read: got v=%b d=%0d want v=1 d=%0d", rd_valid_o, rd_data_o, mf[1]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== '0) begin
            n_fail++; $display("FAIL rst_mid_read: got r=%b v=%b d=%0d want r=0 v=0 d=0", ready_o, rd_valid_o, rd_data_o);
        end
        tick(); tick();
        rst = 1'b0;
        check_gen_window("rst_read_regen");
        test_back_to_back();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; regen_i = 1'b0; rd_en_i = 1'b0; rd_inv_i = 1'b0; rd_addr_i = '0;
        build_model();
        test_reset();
        test_fixed_reads(1'b0, 1, 241, 81, 92);
        test_fixed_reads(1'b1, 1, 16, 165, 176);
        test_back_to_back();
        test_random_reads(40);
        test_regen();
        test_regen_in_gen();
        test_rst_mid_gen();
        test_rst_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psi_table_gen.md
Name: psi_table_gen

Overview:
- Parametrised successor to the fixed twiddle ROMs.
- On reset, or on request, it computes the forward (psi) and inverse (psi^-1) twiddle tables in bit-reversed order into two internal register banks, using a modular multiplier.
- Once ready, it serves single-cycle-latency reads to the NTT/INTT butterfly controller.
- Retargeting to any N/Q/PSI needs only new parameters, not a new hand-written table.

Parameters:
- N, 32, transform length; power of two, >= 4.
- LOG_N, 5, log2(N); address width.
- W, 9, coefficient width; Q < 2^W.
- Q, 257, modulus; prime, Q ≡ 1 mod 2N.
- PSI, 81, primitive 2N-th root of unity mod Q.
- PSI_INV, 165, PSI^-1 mod Q.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- regen  input  1  one-cycle pulse; recompute both tables.
- ready  output  1  tables valid; reads accepted.
- rd_en  input  1  read request.
- rd_inv  input  1  0 = forward bank, 1 = inverse bank.
- rd_addr  input  LOG_N  table index.
- rd_data  output  W  twiddle value.
- rd_valid  output  1  rd_data valid this cycle.

Behaviour:
- Storage: fwd[i] = PSI^bitrev(i) mod Q; inv[i] = PSI_INV^bitrev(i) mod Q. bitrev is over LOG_N bits. Index 0 of each bank is 1.
- States: GEN, RDY. Reset value: state = GEN, k = 0, acc_f = acc_i = 1, ready = 0, rd_valid = 0, rd_data = 0. Bank contents are don't-care until written.
- GEN, each cycle:
  - fwd[bitrev(k)] <= acc_f; inv[bitrev(k)] <= acc_i.
  - acc_f <= (acc_f*PSI) mod Q; acc_i <= (acc_i*PSI_INV) mod Q.
  - k <= k+1.
  - Products are 2W bits wide. Reduction is full, so results are < Q.
  - When k = N-1, go to RDY.
- GEN latency: after rst deasserts, the first write occurs at the first clk edge. After N edges, ready = 1 (registered, asserted on edge N).
- RDY: ready = 1. The tables are static.
- regen pulse, in RDY or GEN: next edge sets state = GEN, k = 0, acc = 1, ready = 0. A pulse during GEN restarts generation from k = 0.
- Read:
  - rd_en = 1 and ready = 1 at edge t → edge t registers rd_data = bank[rd_addr], selected by rd_inv, and rd_valid = 1.
  - Latency is 1 cycle, fully pipelined: back-to-back reads every cycle.
- rd_en while ready = 0: request dropped; rd_valid = 0 next cycle; rd_data holds its last value.
- rd_en coincident with regen in RDY: the read is served from the old contents (rd_valid = 1). ready drops on the same edge.
- rd_valid = 0 in any cycle without an accepted read; rd_data holds.
- rst asserted mid-GEN or mid-read: immediate return to the reset values above, then GEN restarts from k = 0 after deassertion.
- Out-of-range addresses cannot occur (N = 2^LOG_N).

Test Plan:
- Reset release, defaults → ready = 0 for edges 1..31, ready = 1 after edge 32. rd_valid = 0 throughout GEN.
- Forward reads after ready, addr 0/1/16/31 → rd_data 1/241/81/92, each rd_valid one cycle after rd_en.
- Inverse reads (rd_inv = 1), addr 0/1/16/31 → 1/16/165/176. Check fwd[i]*inv[i] mod 257 = 1 for all 32 entries.
- Back-to-back reads of all 64 entries (fwd then inv) → 64 consecutive rd_valid cycles, values matching a software model, no bubbles.
- rd_en during GEN → no rd_valid. regen pulse at edge 40 → ready = 0 from edge 40, ready = 1 after edge 72, contents unchanged.
- rst asserted at k = 10 for 2 cycles → ready = 0 and rd_valid = 0 immediately. Table regenerated correctly; ready after 32 edges post-deassert.
